// File: rtl/mmio_mem_stage.sv
// Memory-stage access unit: decodes RAM, GPIO and N_CH handshaked channels, stalls on channel access.
// Optional MMIO_TIMEOUT_EN aborts a channel wait after TIMEOUT cycles with error data.
module mmio_mem_stage #(
  parameter int          DATA_W    = 32,
  parameter int          N_CH      = 4,
  parameter logic [15:0] RAM_BASE  = 16'h1001,
  parameter logic [15:0] GPIO_BASE = 16'h0008,
  parameter logic [15:0] CH_BASE   = 16'h0010,
  parameter int          GPIO_W    = 8,
  parameter int          TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic                   memwe_i,
  input  logic                   memre_i,
  input  logic [2:0]             memlen_i,
  input  logic [DATA_W-1:0]      addr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic                   cregwa_i,
  input  logic [1:0]             cregwd_i,
  input  logic                   regwe_i,
  input  logic [4:0]             rt_i,
  input  logic [4:0]             rd_i,
  output logic                   ram_we_o,
  output logic [2:0]             ram_len_o,
  output logic [DATA_W-1:0]      ram_addr_o,
  output logic [DATA_W-1:0]      ram_wdata_o,
  input  logic [DATA_W-1:0]      ram_rdata_i,
  output logic [N_CH-1:0]        ch_req_o,
  output logic                   ch_we_o,
  output logic [15:0]            ch_addr_o,
  output logic [DATA_W-1:0]      ch_wdata_o,
  input  logic [N_CH*DATA_W-1:0] ch_rdata_i,
  input  logic [N_CH-1:0]        ch_ack_i,
  output logic                   stall_o,
  output logic [DATA_W-1:0]      memrd_o,
  output logic [GPIO_W-1:0]      gpio_o,
  output logic                   bus_err_o,
  output logic                   we_me,
  output logic [4:0]             wa_me,
  output logic [DATA_W-1:0]      wd_me
);

  // state | meaning
  // IDLE  | no channel access outstanding; RAM/GPIO complete here
  // WAIT  | channel request held, waiting for that channel's ack
  // DONE  | channel result presented, pipeline advances
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic              acc, hit_ram, hit_gpio, any_ch, any_hit, ack_sel;
  logic [15:0]       seg;
  logic [N_CH-1:0]   hit_ch;
  logic [N_CH-1:0]   ch_req_q;
  logic              ch_we_q;
  logic [15:0]       ch_addr_q;
  logic [DATA_W-1:0] ch_wdata_q, rdata_q, rdata_sel;
  logic [GPIO_W-1:0] gpio_q;
  logic              bus_err_q;

  assign acc      = valid_i & (memwe_i | memre_i);
  assign seg      = addr_i[DATA_W-1:DATA_W-16];
  assign hit_ram  = (seg == RAM_BASE);
  assign hit_gpio = (seg == GPIO_BASE);

  for (genvar i = 0; i < N_CH; i++) begin : g_dec
    assign hit_ch[i] = (seg == CH_BASE + 16'(i));
  end

  assign any_ch  = |hit_ch;
  assign any_hit = hit_ram | hit_gpio | any_ch;
  assign ack_sel = |(ch_ack_i & ch_req_q);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_req_q[i]) rdata_sel = rdata_sel | ch_rdata_i[i*DATA_W +: DATA_W];
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] tmo_q;
  logic          tmo_hit;
  // Down-counter loaded on entry so the wait lasts exactly TIMEOUT cycles.
  assign tmo_hit = (tmo_q == '0);

  always_ff @(posedge clk) begin
    if (rst)                                      tmo_q <= '0;
    else if (state_q == S_IDLE && acc && any_ch)  tmo_q <= CW'(TIMEOUT - 1);
    else if (state_q == S_WAIT && !tmo_hit)       tmo_q <= tmo_q - 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (acc && any_ch) state_d = S_WAIT;
      S_WAIT: begin
        if (ack_sel) state_d = S_DONE;
`ifdef MMIO_TIMEOUT_EN
        else if (tmo_hit) state_d = S_DONE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o = ~rst & (((state_q == S_IDLE) & acc & any_ch) | (state_q == S_WAIT));
    memrd_o = '0;
    if (state_q == S_DONE) memrd_o = rdata_q;
    else if (hit_ram)      memrd_o = ram_rdata_i;
    else if (hit_gpio)     memrd_o = {{(DATA_W-GPIO_W){1'b0}}, gpio_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_req_q   <= '0;
      ch_we_q    <= 1'b0;
      ch_addr_q  <= '0;
      ch_wdata_q <= '0;
      rdata_q    <= '0;
      gpio_q     <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && acc && any_ch) begin
        ch_req_q   <= hit_ch;
        ch_we_q    <= memwe_i;
        ch_addr_q  <= addr_i[15:0];
        ch_wdata_q <= wdata_i;
      end
      if (state_q == S_WAIT) begin
        if (ack_sel) begin
          ch_req_q <= '0;
          if (!ch_we_q) rdata_q <= rdata_sel;
        end
`ifdef MMIO_TIMEOUT_EN
        else if (tmo_hit) begin
          ch_req_q  <= '0;
          rdata_q   <= DATA_W'(32'hDEAD_BEEF);
          bus_err_q <= 1'b1;
        end
`endif
      end
      if (acc && memwe_i && hit_gpio) gpio_q <= wdata_i[GPIO_W-1:0];
      if (acc && !any_hit)            bus_err_q <= 1'b1;
    end
  end

  assign ram_we_o    = acc & memwe_i & hit_ram;
  assign ram_len_o   = memlen_i;
  assign ram_addr_o  = addr_i;
  assign ram_wdata_o = wdata_i;
  assign ch_req_o    = ch_req_q;
  assign ch_we_o     = ch_we_q;
  assign ch_addr_o   = ch_addr_q;
  assign ch_wdata_o  = ch_wdata_q;
  assign gpio_o      = gpio_q;
  assign bus_err_o   = bus_err_q;

  assign we_me = regwe_i & ~stall_o;
  assign wa_me = cregwa_i ? rd_i : rt_i;
  always_comb begin
    case (cregwd_i)
      2'b00:   wd_me = addr_i;
      2'b01:   wd_me = memrd_o;
      default: wd_me = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_mem_stage.sv
// Bench for mmio_mem_stage: transaction-level model compared every cycle plus literal checks.
// Timeout scenario runs when MMIO_TIMEOUT_EN is defined.
module tb_mmio_mem_stage;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0, rst;
  logic valid_i, memwe_i, memre_i, cregwa_i, regwe_i;
  logic [2:0] memlen_i;
  logic [DW-1:0] addr_i, wdata_i, ram_rdata_i;
  logic [1:0] cregwd_i;
  logic [4:0] rt_i, rd_i;
  logic ram_we_o, ch_we_o, stall_o, bus_err_o, we_me;
  logic [2:0] ram_len_o;
  logic [DW-1:0] ram_addr_o, ram_wdata_o, ch_wdata_o, memrd_o, wd_me;
  logic [NC-1:0] ch_req_o, ch_ack_i;
  logic [15:0] ch_addr_o;
  logic [NC*DW-1:0] ch_rdata_i;
  logic [7:0] gpio_o;
  logic [4:0] wa_me;

  mmio_mem_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .memwe_i(memwe_i), .memre_i(memre_i),
    .memlen_i(memlen_i), .addr_i(addr_i), .wdata_i(wdata_i), .cregwa_i(cregwa_i),
    .cregwd_i(cregwd_i), .regwe_i(regwe_i), .rt_i(rt_i), .rd_i(rd_i),
    .ram_we_o(ram_we_o), .ram_len_o(ram_len_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ch_req_o(ch_req_o),
    .ch_we_o(ch_we_o), .ch_addr_o(ch_addr_o), .ch_wdata_o(ch_wdata_o),
    .ch_rdata_i(ch_rdata_i), .ch_ack_i(ch_ack_i), .stall_o(stall_o), .memrd_o(memrd_o),
    .gpio_o(gpio_o), .bus_err_o(bus_err_o), .we_me(we_me), .wa_me(wa_me), .wd_me(wd_me)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, stall_cnt = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding channel transaction, a completion flag, GPIO and sticky error.
  bit m_active, m_done, m_err, m_we;
  int m_ch, m_waited;
  logic [7:0] m_gpio;
  logic [15:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  function automatic void decode(input logic [DW-1:0] a, output bit r, output bit g,
                                 output bit c, output int ci);
    int seg;
    seg = int'(a[31:16]);
    r = (seg == 'h1001);
    g = (seg == 'h0008);
    c = (seg >= 'h0010) && (seg < 'h0010 + NC);
    ci = seg - 'h0010;
  endfunction

  always @(posedge clk) begin
    bit r, g, c, acc;
    int ci;
    decode(addr_i, r, g, c, ci);
    acc = valid_i && (memwe_i || memre_i);
    if (rst) begin
      m_active = 0; m_done = 0; m_err = 0; m_gpio = '0; m_rdata = '0;
    end else begin
      if (acc && memwe_i && g) m_gpio = wdata_i[7:0];
      if (acc && !(r || g || c)) m_err = 1;
      if (m_done) m_done = 0;
      else if (m_active) begin
        if (ch_ack_i[m_ch]) begin
          m_active = 0; m_done = 1;
          if (!m_we) m_rdata = ch_rdata_i[m_ch*DW +: DW];
        end
`ifdef MMIO_TIMEOUT_EN
        else if (m_waited == TIMEOUT - 1) begin
          m_active = 0; m_done = 1; m_rdata = 32'hDEAD_BEEF; m_err = 1;
        end
`endif
        else m_waited++;
      end else if (acc && c) begin
        m_active = 1; m_ch = ci; m_we = memwe_i; m_addr = addr_i[15:0];
        m_wdata = wdata_i; m_waited = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit r, g, c, acc, e_stall;
    int ci;
    logic [DW-1:0] e_rd, e_wd;
    if (stall_o) stall_cnt++;
    if (cmp_en) begin
      decode(addr_i, r, g, c, ci);
      acc = valid_i && (memwe_i || memre_i);
      e_stall = !rst && (m_active || (!m_done && acc && c));
      e_rd = m_done ? m_rdata : r ? ram_rdata_i : g ? {24'b0, m_gpio} : '0;
      e_wd = (cregwd_i == 2'b01) ? e_rd : (cregwd_i == 2'b00) ? addr_i : '0;
      chk("stall", stall_o, e_stall);
      chk("ch_req", ch_req_o, m_active ? (4'b1 << m_ch) : 4'b0);
      chk("ram_we", ram_we_o, acc && memwe_i && r);
      chk("ram_pass", {ram_len_o, ram_addr_o, ram_wdata_o}, {memlen_i, addr_i, wdata_i});
      chk("memrd", memrd_o, e_rd);
      chk("gpio", gpio_o, m_gpio);
      chk("bus_err", bus_err_o, m_err);
      chk("we_me", we_me, regwe_i && !e_stall);
      chk("wa_me", wa_me, cregwa_i ? rd_i : rt_i);
      chk("wd_me", wd_me, e_wd);
      if (m_active) chk("ch_hold", {ch_we_o, ch_addr_o, ch_wdata_o}, {m_we, m_addr, m_wdata});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input bit we, input bit re, input logic [DW-1:0] a,
                       input logic [DW-1:0] wd, input logic [1:0] cwd, input bit rwe);
    valid_i = v; memwe_i = we; memre_i = re; addr_i = a; wdata_i = wd;
    cregwd_i = cwd; regwe_i = rwe;
  endtask

  initial begin
    rst = 1; ch_ack_i = '0; ch_rdata_i = '0; ram_rdata_i = 32'h0BAD_F00D;
    memlen_i = 3'd2; cregwa_i = 1; rt_i = 5'd3; rd_i = 5'd7;
    drive(0, 0, 0, '0, '0, 2'b00, 0);
    step(); step();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_gpio", gpio_o, 8'h00);
    chk("rst_err", bus_err_o, 1'b0);
    chk("rst_req", ch_req_o, 4'b0000);
    step(); rst = 0;

    // GPIO store then load; a load with wdata=FF must not disturb GPIO
    drive(1, 1, 0, 32'h0008_0000, 32'h0000_00A5, 2'b10, 0);
    step();
    drive(1, 0, 1, 32'h0008_0004, 32'h0000_00FF, 2'b01, 1);
    @(negedge clk);
    chk("gpio_a5", gpio_o, 8'hA5);
    chk("gpio_load", memrd_o, 32'h0000_00A5);
    chk("gpio_nostall", stall_o, 1'b0);
    step();
    drive(1, 0, 1, 32'h0008_0000, 32'h0000_00FF, 2'b01, 1);
    step();
    drive(0, 0, 0, '0, '0, 2'b00, 0);
    @(negedge clk);
    chk("gpio_load_nowrite", gpio_o, 8'hA5);

    // channel 2 load, ack on the 4th WAIT cycle
    step();
    ch_rdata_i[2*DW +: DW] = 32'h1234_5678;
    stall_cnt = 0;
    drive(1, 0, 1, 32'h0012_0040, '0, 2'b01, 1);
    step();
    @(negedge clk);
    chk("ch2_req", ch_req_o, 4'b0100);
    chk("ch2_addr", ch_addr_o, 16'h0040);
    step(); step(); step();
    ch_ack_i = 4'b0100;
    step();
    ch_ack_i = '0;
    @(negedge clk);
    chk("ch2_data", memrd_o, 32'h1234_5678);
    chk("ch2_we_me", we_me, 1'b1);
    chk("ch2_stall_cycles", stall_cnt, 5);
    step();
    drive(0, 0, 0, '0, '0, 2'b00, 0);

    // channel 1 store: foreign acks ignored, own ack completes
    step();
    drive(1, 1, 0, 32'h0011_0008, 32'hCAFE_0001, 2'b10, 0);
    step();
    ch_ack_i = 4'b1101;
    step(); step();
    @(negedge clk);
    chk("ch1_still_wait", stall_o, 1'b1);
    chk("ch1_we", ch_we_o, 1'b1);
    chk("ch1_wdata", ch_wdata_o, 32'hCAFE_0001);
    ch_ack_i = 4'b0010;
    step();
    ch_ack_i = '0;
    @(negedge clk);
    chk("ch1_done", stall_o, 1'b0);
    step();

    // RAM store/load and forwarding of ALU result
    cregwa_i = 0;
    drive(1, 1, 0, 32'h1001_0010, 32'h5555_AAAA, 2'b00, 1);
    @(negedge clk);
    chk("ram_we_lit", ram_we_o, 1'b1);
    chk("ram_fwd_alu", wd_me, 32'h1001_0010);
    step();
    drive(1, 0, 1, 32'h1001_0014, '0, 2'b01, 1);
    @(negedge clk);
    chk("ram_load", memrd_o, 32'h0BAD_F00D);
    step();

    // unmapped access sets sticky error
    drive(1, 0, 1, 32'h0050_0000, '0, 2'b01, 1);
    @(negedge clk);
    chk("unmapped_rd", memrd_o, 32'h0);
    step();
    drive(0, 0, 0, '0, '0, 2'b00, 0);
    step(); step(); step();
    @(negedge clk);
    chk("bus_err_sticky", bus_err_o, 1'b1);

    // reset in WAIT drops request and stall
    step();
    drive(1, 0, 1, 32'h0013_0000, '0, 2'b01, 1);
    step(); step();
    rst = 1;
    step();
    @(negedge clk);
    chk("rst_wait_req", ch_req_o, 4'b0000);
    chk("rst_wait_stall", stall_o, 1'b0);
    chk("rst_wait_err", bus_err_o, 1'b0);
    drive(0, 0, 0, '0, '0, 2'b00, 0);
    step(); rst = 0;
    step();

    // no ack on channel 0
    stall_cnt = 0;
    drive(1, 0, 1, 32'h0010_0000, '0, 2'b01, 1);
`ifdef MMIO_TIMEOUT_EN
    step();
    for (int k = 0; k < 40 && stall_o; k++) step();
    @(negedge clk);
    chk("tmo_data", memrd_o, 32'hDEAD_BEEF);
    chk("tmo_err", bus_err_o, 1'b1);
    chk("tmo_stall_cycles", stall_cnt, TIMEOUT + 1);
    step();
`else
    repeat (20) step();
    @(negedge clk);
    chk("nack_holds", stall_o, 1'b1);
    chk("nack_req", ch_req_o, 4'b0001);
    ch_rdata_i[0 +: DW] = 32'h0000_0777;
    ch_ack_i = 4'b0001;
    step();
    ch_ack_i = '0;
    @(negedge clk);
    chk("nack_late_data", memrd_o, 32'h0000_0777);
    step();
`endif
    drive(0, 0, 0, '0, '0, 2'b00, 0);
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_mem_stage.md
Name: mmio_mem_stage

Overview:
Parametrised memory-stage access unit for the pipeline CPU. It decodes the ALU address into data RAM, a GPIO register and N_CH handshaked peripheral channels (VGA, timers, etc.). Channel accesses take multiple cycles and stall the pipeline; RAM and GPIO accesses complete in one cycle. It also produces the writeback-forwarding triple for the hazard unit.

Parameters:
DATA_W, 32, data/address width
N_CH, 4, number of handshaked peripheral channels (1..8)
RAM_BASE, 16'h1001, addr[31:16] value selecting data RAM
GPIO_BASE, 16'h0008, addr[31:16] value selecting GPIO register
CH_BASE, 16'h0010, channel i selected when addr[31:16] == CH_BASE+i
GPIO_W, 8, GPIO register width
TIMEOUT, 15, max WAIT cycles before abort (only with MMIO_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
valid_i  in  1  memory-stage instruction valid
memwe_i  in  1  store
memre_i  in  1  load
memlen_i  in  3  access length code, forwarded to RAM only
addr_i  in  DATA_W  ALU result / address
wdata_i  in  DATA_W  store data
cregwa_i  in  1  1: dest = rd_i, 0: dest = rt_i
cregwd_i  in  2  00: ALU, 01: memory read, else 0
regwe_i  in  1  register write enable
rt_i, rd_i  in  5 each  register specifiers
ram_we_o  out  1  RAM write strobe
ram_len_o  out  3  = memlen_i
ram_addr_o, ram_wdata_o  out  DATA_W  = addr_i, wdata_i
ram_rdata_i  in  DATA_W  combinational RAM read data
ch_req_o  out  N_CH  one-hot channel request
ch_we_o  out  1  channel write
ch_addr_o  out  16  addr[15:0] of held access
ch_wdata_o  out  DATA_W  held store data
ch_rdata_i  in  N_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
ch_ack_i  in  N_CH  per-channel completion
stall_o  out  1  freeze IF..MEM
memrd_o  out  DATA_W  load result
gpio_o  out  GPIO_W  GPIO register
bus_err_o  out  1  sticky error
we_me, wa_me[4:0], wd_me[DATA_W-1:0]  out  forwarding triple

Behaviour:
- acc = valid_i & (memwe_i | memre_i). Decode on addr_i[31:16]; at most one hit.
- RAM: ram_we_o = acc & memwe_i & hit_ram, combinational. memrd_o = ram_rdata_i.
- GPIO: on rising clk, if acc & memwe_i & hit_gpio then gpio_o <= wdata_i[GPIO_W-1:0]. Loads return zero-extended gpio_o. Loads do not modify it.
- Unmapped access: store ignored, load returns 0, bus_err_o <= 1.
- FSM states are IDLE, WAIT and DONE.
- IDLE -> WAIT when acc & hit_ch[i]. At that edge, register ch_req_o = one-hot i and latch ch_we_o, ch_addr_o and ch_wdata_o. These hold stable through WAIT.
- WAIT: sample only ch_ack_i[i]; acks on other channels are ignored. On ack: rdata_q <= ch_rdata_i[i] if load, else unchanged. Also ch_req_o <= 0 and go to DONE.
- DONE: the pipeline advances this cycle. memrd_o = rdata_q. Next state is IDLE unconditionally, so the same instruction is never reissued.
- stall_o = (IDLE & acc & any hit_ch) | WAIT. It is 0 in DONE. Minimum channel latency is 3 cycles: IDLE, WAIT, DONE.
- Forwarding:
  - we_me = regwe_i & ~stall_o.
  - wa_me = cregwa_i ? rd_i : rt_i.
  - wd_me = memrd_o when cregwd_i=01; addr_i when 00; else 0.
- Reset (synchronous, wins over all): state IDLE, ch_req_o 0, ch_we_o 0, ch_addr_o 0, ch_wdata_o 0, rdata_q 0, gpio_o 0, bus_err_o 0, timeout counter 0. Reset during WAIT drops ch_req_o at that edge and deasserts stall_o.
- bus_err_o is cleared only by rst.

Optional Feature:
- Macro: MMIO_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles from 0.
  - If the count reaches TIMEOUT with no ack: ch_req_o <= 0, rdata_q <= 32'hDEAD_BEEF, bus_err_o <= 1, go to DONE.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; WAIT holds indefinitely until ack.

Test Plan:
- Store 0xA5 to 0x0008_0000, then load 0x0008_0004 -> gpio_o=8'hA5 after the edge; memrd_o=32'h0000_00A5; stall_o stays 0.
- Load 0x0008_0000 with memwe_i=0 and wdata_i=0xFF -> gpio_o unchanged (regression: loads must not write GPIO).
- Load from channel 2 (0x0012_0040), ack after 4 WAIT cycles with data 0x1234_5678 -> ch_req_o=4'b0100 and ch_addr_o=16'h0040 held; stall_o high for 5 cycles; DONE gives memrd_o=0x1234_5678, we_me=1.
- WAIT on channel 1 with ch_ack_i=4'b1101 -> no completion; ack on bit 1 completes it.
- Store to 0x1001_0010 -> ram_we_o=1 the same cycle, no stall. Access to 0x0050_0000 -> bus_err_o=1 and stays 1.
- With MMIO_TIMEOUT_EN, give no ack -> abort after 15 WAIT cycles; memrd_o=32'hDEAD_BEEF; bus_err_o=1. Assert rst mid-WAIT -> ch_req_o=0 and stall_o=0 next cycle.
